// File: rtl/bht_update_queue_pkg.sv
// Shared types for the BHT update queue: the stored entry layout and the
// pointer-width helper (queue index plus one wrap bit).
package bht_update_queue_pkg;

    localparam int unsigned BHT_VLEN       = 64;
    localparam int unsigned BHT_INDEX_BITS = 9;

    typedef struct packed {
        logic [BHT_VLEN-1:0]       pc;
        logic                      taken;
        logic [BHT_INDEX_BITS-1:0] index;
    } bht_updq_entry_t;

    function automatic int unsigned updq_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bht_update_queue_checker.sv
// Protocol checks for bht_update_queue: flags a commit with no uncommitted entry.
module bht_updq_checker #(
    parameter int unsigned PW = 3
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          commit_i,
    input logic [PW-1:0] cmt_q,
    input logic [PW-1:0] wr_q
);

    a_commit_nonempty: assert property (
        @(posedge clk_i) disable iff (!rst_ni) commit_i |-> (cmt_q != wr_q)
    ) else $error("commit_i with no uncommitted entry");

endmodule

// File: rtl/bht_update_queue_stats.sv
// Saturating statistics counters for accepted and mispredicted branches.
// Instantiated by bht_update_queue only when BHT_UPDQ_STATS_EN is defined.
module bht_updq_stats #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_branch_i,
    input  logic             inc_mispred_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    logic [CNT_W-1:0] branch_q, branch_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    // next-state: increment unless already at all-ones
    always_comb begin
        branch_d  = branch_q;
        mispred_d = mispred_q;
        if (inc_branch_i && (branch_q != {CNT_W{1'b1}})) begin
            branch_d = branch_q + CNT_W'(1'b1);
        end else begin
            branch_d = branch_q;
        end
        if (inc_mispred_i && (mispred_q != {CNT_W{1'b1}})) begin
            mispred_d = mispred_q + CNT_W'(1'b1);
        end else begin
            mispred_d = mispred_q;
        end
    end

    // counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else begin
            branch_q  <= branch_d;
            mispred_q <= mispred_d;
        end
    end

    assign branch_cnt_o     = branch_q;
    assign mispredict_cnt_o = mispred_q;

endmodule

// File: rtl/bht_update_queue.sv
// BHT update queue: holds resolved conditional branches until commit, then
// drains them in order. Optional statistics under macro BHT_UPDQ_STATS_EN.
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned VLEN       = BHT_VLEN,
    parameter int unsigned INDEX_BITS = BHT_INDEX_BITS,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  flush_bp_i,
    input  logic                  debug_mode_i,
    input  logic                  resolve_valid_i,
    input  logic                  resolve_is_cond_i,
    input  logic [VLEN-1:0]       resolve_pc_i,
    input  logic                  resolve_taken_i,
    input  logic                  resolve_pred_taken_i,
    input  logic [INDEX_BITS-1:0] resolve_index_i,
    input  logic                  commit_i,
    output logic                  upd_valid_o,
    input  logic                  upd_ready_i,
    output logic [VLEN-1:0]       upd_pc_o,
    output logic                  upd_taken_o,
    output logic [INDEX_BITS-1:0] upd_index_o,
    output logic                  dropped_o,
    output logic [CNT_W-1:0]      branch_cnt_o,
    output logic [CNT_W-1:0]      mispredict_cnt_o
);

    localparam int unsigned PW = updq_ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   cmt_q, cmt_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic            dropped_q, dropped_d;
    bht_updq_entry_t mem_q [DEPTH];
    bht_updq_entry_t head_s;

    logic [PW-1:0] occ_s;
    logic          full_s;
    logic          push_s;
    logic          accept_s;
    logic          commit_ok_s;
    logic          pop_s;

    // Full and commit eligibility use start-of-cycle pointers only, so a
    // same-cycle pop never frees a slot for the push.
    assign occ_s       = wr_q - rd_q;
    assign full_s      = (occ_s == PW'(DEPTH));
    assign push_s      = resolve_valid_i & resolve_is_cond_i & ~debug_mode_i
                       & ~flush_i & ~flush_bp_i;
    assign accept_s    = push_s & ~full_s;
    assign commit_ok_s = commit_i & (cmt_q != wr_q);
    assign pop_s       = upd_valid_o & upd_ready_i;

    // pointer next-state; predictor flush overrides everything else
    always_comb begin
        rd_d      = rd_q;
        cmt_d     = cmt_q;
        wr_d      = wr_q;
        dropped_d = push_s & full_s;
        if (flush_bp_i) begin
            rd_d  = '0;
            cmt_d = '0;
            wr_d  = '0;
        end else begin
            if (pop_s) begin
                rd_d = rd_q + PW'(1'b1);
            end else begin
                rd_d = rd_q;
            end
            if (commit_ok_s) begin
                cmt_d = cmt_q + PW'(1'b1);
            end else begin
                cmt_d = cmt_q;
            end
            if (flush_i) begin
                wr_d = cmt_d;
            end else if (accept_s) begin
                wr_d = wr_q + PW'(1'b1);
            end else begin
                wr_d = wr_q;
            end
        end
    end

    // pointer and drop-pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q      <= '0;
            cmt_q     <= '0;
            wr_q      <= '0;
            dropped_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            cmt_q     <= cmt_d;
            wr_q      <= wr_d;
            dropped_q <= dropped_d;
        end
    end

    // entry storage; contents are don't-care out of reset
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            mem_q[wr_q[AW-1:0]] <= '{pc:    BHT_VLEN'(resolve_pc_i),
                                     taken: resolve_taken_i,
                                     index: BHT_INDEX_BITS'(resolve_index_i)};
        end
    end

    assign head_s      = mem_q[rd_q[AW-1:0]];
    assign upd_valid_o = (rd_q != cmt_q);
    assign upd_pc_o    = VLEN'(head_s.pc);
    assign upd_taken_o = head_s.taken;
    assign upd_index_o = INDEX_BITS'(head_s.index);
    assign dropped_o   = dropped_q;

`ifdef BHT_UPDQ_STATS_EN
    bht_updq_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .inc_branch_i     (accept_s),
        .inc_mispred_i    (accept_s & (resolve_taken_i ^ resolve_pred_taken_i)),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );
`else
    logic unused_pred_s;
    assign unused_pred_s    = resolve_pred_taken_i;
    assign branch_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

    bht_updq_checker #(
        .PW(PW)
    ) u_checker (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .commit_i (commit_i),
        .cmt_q    (cmt_q),
        .wr_q     (wr_q)
    );

endmodule

// File: tb/tb_bht_update_queue.sv
// Self-checking bench for bht_update_queue: directed scenarios followed by
// randomized traffic, compared each cycle against a queue-based model.
module tb_bht_update_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, flush_bp_i, debug_mode_i;
    logic        resolve_valid_i, resolve_is_cond_i;
    logic [63:0] resolve_pc_i;
    logic        resolve_taken_i, resolve_pred_taken_i;
    logic [8:0]  resolve_index_i;
    logic        commit_i;
    logic        upd_valid_o, upd_ready_i;
    logic [63:0] upd_pc_o;
    logic        upd_taken_o;
    logic [8:0]  upd_index_o;
    logic        dropped_o;
    logic [31:0] branch_cnt_o, mispredict_cnt_o;

    bht_update_queue dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .flush_i              (flush_i),
        .flush_bp_i           (flush_bp_i),
        .debug_mode_i         (debug_mode_i),
        .resolve_valid_i      (resolve_valid_i),
        .resolve_is_cond_i    (resolve_is_cond_i),
        .resolve_pc_i         (resolve_pc_i),
        .resolve_taken_i      (resolve_taken_i),
        .resolve_pred_taken_i (resolve_pred_taken_i),
        .resolve_index_i      (resolve_index_i),
        .commit_i             (commit_i),
        .upd_valid_o          (upd_valid_o),
        .upd_ready_i          (upd_ready_i),
        .upd_pc_o             (upd_pc_o),
        .upd_taken_o          (upd_taken_o),
        .upd_index_o          (upd_index_o),
        .dropped_o            (dropped_o),
        .branch_cnt_o         (branch_cnt_o),
        .mispredict_cnt_o     (mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [8:0]  idx;
    } m_ent_t;

    m_ent_t mq[$];       // all live entries, oldest first
    int     ncmt;        // committed-but-not-drained count at the head of mq
    logic   exp_drop;
    longint exp_br, exp_mis;
    int     checks = 0;
    int     errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] occ;
        occ = dut.wr_q - dut.rd_q;
        chk_eq("valid", 64'(upd_valid_o), 64'(ncmt > 0));
        if (ncmt > 0) begin
            chk_eq("pc", upd_pc_o, mq[0].pc);
            chk_eq("taken", 64'(upd_taken_o), 64'(mq[0].taken));
            chk_eq("index", 64'(upd_index_o), 64'(mq[0].idx));
        end
        chk_eq("dropped", 64'(dropped_o), 64'(exp_drop));
        chk_eq("occupancy", 64'(occ), 64'(mq.size()));
`ifdef BHT_UPDQ_STATS_EN
        chk_eq("branch_cnt", 64'(branch_cnt_o), 64'(exp_br));
        chk_eq("mispred_cnt", 64'(mispredict_cnt_o), 64'(exp_mis));
`else
        chk_eq("branch_cnt", 64'(branch_cnt_o), 64'd0);
        chk_eq("mispred_cnt", 64'(mispredict_cnt_o), 64'd0);
`endif
    endtask

    task automatic model_reset();
        mq.delete();
        ncmt     = 0;
        exp_drop = 1'b0;
        exp_br   = 0;
        exp_mis  = 0;
    endtask

    // One cycle: check outputs, drive inputs, advance the model.
    task automatic step(input logic v, input logic cond, input logic [63:0] pc,
                        input logic tk, input logic pt, input logic [8:0] idx,
                        input logic cmt, input logic rdy, input logic fl,
                        input logic fbp, input logic dbg);
        logic full, pushq, cmt_ok, pop;
        m_ent_t e;
        @(negedge clk_i);
        check_outputs();
        resolve_valid_i      = v;
        resolve_is_cond_i    = cond;
        resolve_pc_i         = pc;
        resolve_taken_i      = tk;
        resolve_pred_taken_i = pt;
        resolve_index_i      = idx;
        commit_i             = cmt;
        upd_ready_i          = rdy;
        flush_i              = fl;
        flush_bp_i           = fbp;
        debug_mode_i         = dbg;

        full   = (mq.size() == 4);
        pushq  = v && cond && !dbg && !fl && !fbp;
        cmt_ok = cmt && (mq.size() > ncmt);
        pop    = (ncmt > 0) && rdy;
        exp_drop = pushq && full;
        if (pushq && !full) begin
            exp_br++;
            if (tk != pt) exp_mis++;
        end
        if (fbp) begin
            mq.delete();
            ncmt = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                ncmt--;
            end
            if (cmt_ok) ncmt++;
            if (fl) begin
                while (mq.size() > ncmt) void'(mq.pop_back());
            end else if (pushq && !full) begin
                e.pc = pc; e.taken = tk; e.idx = idx;
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 64'd0, 0, 0, 9'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [63:0] pc, input logic tk, input logic pt, input logic [8:0] idx);
        step(1, 1, pc, tk, pt, idx, 0, 0, 0, 0, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk_i);
        resolve_valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
        flush_bp_i = 1'b0; upd_ready_i = 1'b0; debug_mode_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        model_reset();
        chk_eq("rst_valid", 64'(upd_valid_o), 64'd0);
        chk_eq("rst_dropped", 64'(dropped_o), 64'd0);
        chk_eq("rst_branch_cnt", 64'(branch_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic v, cond, tk, pt, cmt, rdy, fl, fbp, dbg;
        logic [63:0] pc;
        logic [8:0]  idx;
        rst_ni = 1'b0;
        flush_i = 1'b0; flush_bp_i = 1'b0; debug_mode_i = 1'b0;
        resolve_valid_i = 1'b0; resolve_is_cond_i = 1'b0; resolve_pc_i = 64'd0;
        resolve_taken_i = 1'b0; resolve_pred_taken_i = 1'b0; resolve_index_i = 9'd0;
        commit_i = 1'b0; upd_ready_i = 1'b0;
        model_reset();
        #12;
        chk_eq("reset_valid", 64'(upd_valid_o), 64'd0);
        chk_eq("reset_dropped", 64'(dropped_o), 64'd0);
        chk_eq("reset_branch_cnt", 64'(branch_cnt_o), 64'd0);
        chk_eq("reset_mispred_cnt", 64'(mispredict_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // single push, commit, drain
        push(64'h8000_0010, 1, 1, 9'd5);
        step(0, 0, 64'd0, 0, 0, 9'd0, 1, 1, 0, 0, 0);
        idle(3);

        // overflow: fifth push dropped
        for (int i = 0; i < 5; i++) push(64'h1000 + 64'(i * 4), i[0], 0, 9'(i));
        idle(2);
        step(0, 0, 64'd0, 0, 0, 9'd0, 0, 0, 0, 1, 0);

        // flush keeps only committed entry
        for (int i = 0; i < 3; i++) push(64'h2000 + 64'(i * 4), 1, 0, 9'(10 + i));
        step(0, 0, 64'd0, 0, 0, 9'd0, 1, 0, 0, 0, 0);
        step(0, 0, 64'd0, 0, 0, 9'd0, 0, 0, 1, 0, 0);
        step(0, 0, 64'd0, 0, 0, 9'd0, 0, 1, 0, 0, 0);
        idle(2);

        // backpressure then in-order drain
        push(64'h3000, 1, 1, 9'd20);
        push(64'h3004, 0, 0, 9'd21);
        step(0, 0, 64'd0, 0, 0, 9'd0, 1, 0, 0, 0, 0);
        step(0, 0, 64'd0, 0, 0, 9'd0, 1, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 64'd0, 0, 0, 9'd0, 0, 1, 0, 0, 0);
        step(0, 0, 64'd0, 0, 0, 9'd0, 0, 1, 0, 0, 0);
        idle(1);

        // predictor flush with push, commit and pop in the same cycle
        for (int i = 0; i < 3; i++) push(64'h4000 + 64'(i * 4), 0, 1, 9'(30 + i));
        step(0, 0, 64'd0, 0, 0, 9'd0, 1, 0, 0, 0, 0);
        step(0, 0, 64'd0, 0, 0, 9'd0, 1, 0, 0, 0, 0);
        step(1, 1, 64'h4100, 1, 1, 9'd40, 1, 1, 0, 1, 0);
        idle(2);

        // statistics after a fresh reset
        mid_reset();
        push(64'h5000, 1, 1, 9'd1);
        push(64'h5004, 1, 0, 9'd2);
        push(64'h5008, 0, 0, 9'd3);
        push(64'h500c, 0, 1, 9'd4);
        step(1, 1, 64'h5010, 1, 0, 9'd5, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 64'd0, 0, 0, 9'd0, 0, 0, 0, 1, 0);

        // randomized traffic with one asynchronous reset in the middle
        for (int c = 0; c < 600; c++) begin
            if (c == 300) mid_reset();
            v    = ($urandom_range(0, 99) < 60);
            cond = ($urandom_range(0, 99) < 85);
            pc   = {$urandom(), $urandom()};
            tk   = 1'($urandom());
            pt   = 1'($urandom());
            idx  = 9'($urandom());
            cmt  = (mq.size() > ncmt) && ($urandom_range(0, 99) < 55);
            rdy  = ($urandom_range(0, 99) < 65);
            fl   = ($urandom_range(0, 99) < 5);
            fbp  = ($urandom_range(0, 99) < 2);
            dbg  = ($urandom_range(0, 99) < 5);
            step(v, cond, pc, tk, pt, idx, cmt, rdy, fl, fbp, dbg);
        end
        idle(1);
        @(negedge clk_i);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Producer side of the branch-history-table update port. Collects resolved conditional branches from the execute stage and holds them until the commit stage confirms them. Drains committed outcomes in order, one per handshake, as BHT update requests carrying pc, taken and the prediction-time row index (metadata). Sits between the branch unit/commit logic and the frontend BHT.

## Interface
- `VLEN`, 64: virtual address width.
- `INDEX_BITS`, 9: width of the BHT row index carried in metadata.
- `DEPTH`, 4: queue entries; power of two, >= 2.
- `CNT_W`, 32: statistics counter width.

- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous reset, active-low.
- `flush_i`  in  1: pipeline flush; kill uncommitted entries.
- `flush_bp_i`  in  1: predictor flush; kill all entries.
- `debug_mode_i`  in  1: core in debug mode; no new entries are accepted.
- `resolve_valid_i`  in  1: resolved control-flow instruction this cycle.
- `resolve_is_cond_i`  in  1: instruction is a conditional branch.
- `resolve_pc_i`  in  VLEN: branch pc.
- `resolve_taken_i`  in  1: actual outcome.
- `resolve_pred_taken_i`  in  1: outcome predicted by the BHT.
- `resolve_index_i`  in  INDEX_BITS: metadata.index captured at prediction.
- `commit_i`  in  1: oldest uncommitted entry is committed.
- `upd_valid_o`  out  1: update request valid.
- `upd_ready_i`  in  1: BHT/arbiter accepts the update.
- `upd_pc_o`  out  VLEN: update pc.
- `upd_taken_o`  out  1: update outcome.
- `upd_index_o`  out  INDEX_BITS: update row index.
- `dropped_o`  out  1: one-cycle pulse; a qualifying push was discarded.
- `branch_cnt_o`  out  CNT_W: accepted branches (statistics).
- `mispredict_cnt_o`  out  CNT_W: accepted mispredicted branches (statistics).

## Operation
- Three pointers: `rd`, `cmt`, `wr`. Each is log2(DEPTH)+1 bits, including a wrap bit. Invariant: rd <= cmt <= wr (modular). Occupancy is wr-rd; full when occupancy == DEPTH.
- Push condition: resolve_valid_i & resolve_is_cond_i & !debug_mode_i & !flush_i & !flush_bp_i.
  - If not full: write {pc, taken, index} at wr and increment wr.
  - If full: discard the entry and pulse dropped_o. Full is evaluated on registered state, so a same-cycle pop does not free a slot.
- commit_i: increment cmt if cmt != wr, evaluated on the start-of-cycle state. A commit with cmt == wr is ignored and flagged by a simulation assertion.
- flush_i: after this cycle's commit is applied, set wr <= cmt. Committed entries survive.
- flush_bp_i: rd, cmt and wr are all set to 0. This takes priority over every other event in the cycle, including the pop.
- Drain:
  - upd_valid_o = (rd != cmt). Outputs are read from the entry at rd.
  - On upd_valid_o & upd_ready_i, increment rd.
  - Outputs stay stable while valid and not ready.
- Entries are never reordered or coalesced. Updates emerge in commit order.

## Timing
- Reset: all pointers 0, upd_valid_o=0, dropped_o=0, counters 0. Storage contents are don't-care.
- Storage is registered. upd_* outputs are combinational from registered state only, with no input-to-output path.
- Push at cycle N makes the entry committable from cycle N+1. A commit in cycle N cannot target an entry pushed in cycle N.
- commit_i at cycle N raises upd_valid_o at N+1 if this entry is at the head.
- Peak throughput: one push, one commit and one pop per cycle.
- dropped_o is registered and asserts the cycle after the discarded push.
- On reset assertion mid-operation, all state clears immediately (asynchronous). In-flight entries are lost.

## Configuration
- `BHT_UPDQ_STATS_EN` defined:
  - branch_cnt_o increments on every accepted push.
  - mispredict_cnt_o increments when taken != pred_taken on an accepted push.
  - Both counters saturate at all-ones.
  - Flushes do not clear them.
- Not defined: counters are not instantiated and both outputs are tied to 0. The ports remain.

## Structure
- Shared package: `bht_updq_entry_t` {pc, taken, index}, and a pointer-width localparam function.
- Sub-module `bht_updq_stats` holds the two saturating counters. It is instantiated only under `BHT_UPDQ_STATS_EN`.

## Test plan
- Push pc=0x80000010, taken=1, index=5; commit next cycle with upd_ready_i=1 -> upd_valid_o at commit+1 with pc 0x80000010, taken 1, index 5; queue empty after.
- 5 pushes with DEPTH=4 and no commits -> 5th discarded, dropped_o pulses once, occupancy 4.
- 3 pushes, 1 commit, then flush_i -> only the first entry drains; wr==cmt afterwards.
- 2 committed entries with upd_ready_i=0 for 3 cycles -> outputs stable; then ready=1 -> drained in order over 2 cycles.
- flush_bp_i together with a push, commit and pop -> all pointers 0, upd_valid_o=0 next cycle, push lost.
- Stats enabled: 4 accepted pushes, 2 with taken != pred_taken, plus one push with debug_mode_i=1 -> branch_cnt_o=4, mispredict_cnt_o=2.
